multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//   Multi-cycle control FSM for the LOAD/STORE/MOV/MAC datapath; replaces single-cycle decode.
//   Accepts one opcode per valid/ready handshake and sequences DECODE/EXEC/MEM/WB.
//   Drives register-file, memory, ALU and PC enables.
//   Supports a variable-latency memory with timeout, a multi-cycle MAC and a retired-instruction counter.
// PARAMETERS
//   OPCODE_WIDTH  3   opcode width; LOAD=0, STORE=1, MOV=2, MAC=4, all other codes illegal
//   MAC_CYCLES    4   EXEC cycles for MAC, >=1
//   MEM_TIMEOUT   15  max MEM-state cycles waiting for mem_ready before abort, >=1
//   CNT_WIDTH     16  width of retired-instruction counter
// PORTS
//   clk          in   1             clock, rising edge
//   rst_n        in   1             synchronous active-low reset
//   instr_valid  in   1             opcode valid
//   instr_ready  out  1             ctrl can accept opcode (high only in FETCH)
//   opcode       in   OPCODE_WIDTH  instruction opcode, sampled on handshake
//   mem_ready    in   1             memory completes current access
//   RegWEn       out  1             register-file write enable
//   MemWEn       out  1             memory write enable
//   MemREn       out  1             memory read enable
//   AluEn        out  1             MAC unit enable
//   PCWEn        out  1             PC advance, one pulse per retired instruction
//   illegal      out  1             one-cycle pulse: illegal opcode dropped
//   mem_err      out  1             one-cycle pulse: memory timeout abort
//   busy         out  1             high in any state other than FETCH
//   retired      out  CNT_WIDTH     count of PCWEn pulses, wraps to 0
// BEHAVIOUR
//   - rst_n sampled low at posedge: state=FETCH, op_q=0, mac_cnt=0, mem_cnt=0, retired=0.
//     Resulting outputs: instr_ready=1, all other outputs 0. Reset mid-instruction aborts it: no PCWEn, no count.
//   - All enables are Moore outputs decoded from the state register and op_q; no combinational path from inputs.
//   - FETCH: instr_ready=1; on instr_valid&&instr_ready, op_q<=opcode -> DECODE. Else stay.
//   - DECODE (1 cycle), branch on op_q:
//       LOAD/STORE -> MEM, mem_cnt<=0
//       MOV        -> WB
//       MAC        -> EXEC, mac_cnt<=MAC_CYCLES-1
//       other      -> FETCH with illegal=1 for exactly that DECODE cycle; no PCWEn
//   - EXEC: AluEn=1; mac_cnt decrements each cycle; at mac_cnt==0 -> WB.
//     MAC occupies exactly MAC_CYCLES EXEC cycles.
//   - MEM: MemREn=1 (LOAD) or MemWEn=1 (STORE), held stable every MEM cycle.
//       mem_ready=1       -> LOAD: WB; STORE: RET
//       else mem_cnt==MEM_TIMEOUT-1 -> FETCH, mem_err=1 in that last MEM cycle, no PCWEn
//       else mem_cnt++
//     mem_ready and timeout in the same cycle: mem_ready wins.
//   - WB: RegWEn=1 for one cycle -> RET.
//   - RET: PCWEn=1 for one cycle, retired<=retired+1 (mod 2^CNT_WIDTH) -> FETCH.
//   - Latency, handshake to next instr_ready:
//       MOV 3; LOAD 4+k; STORE 3+k (k=mem wait cycles); MAC 3+MAC_CYCLES; illegal 1.
//   - instr_valid ignored while busy; opcode changes outside the handshake have no effect.
//   - mem_ready outside MEM is ignored.
// TESTING
//   - Reset: hold rst_n=0 2 cycles -> instr_ready=1, busy=0, retired=0, all enables 0.
//   - MOV, then LOAD with mem_ready on 1st MEM cycle:
//       RegWEn 1 cycle each; PCWEn 2 pulses; retired=2; MOV ready again 3 cycles after handshake.
//   - MAC, MAC_CYCLES=4: AluEn high exactly 4 cycles, then RegWEn 1 cycle, then PCWEn 1 cycle.
//   - STORE with mem_ready at wait 3: MemWEn high 4 cycles, RegWEn never asserts, retired+1.
//     STORE with mem_ready never asserted: mem_err pulse after 15 MEM cycles, no PCWEn.
//   - opcode=3'b111: illegal pulse 1 cycle, FETCH next cycle, no enables.
//     rst_n=0 during MAC EXEC: FETCH next cycle, no PCWEn.
//   - CNT_WIDTH=2, retire 5 MOVs -> retired sequence 1,2,3,0,1 (wrap).

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the LOAD/STORE/MOV/MAC datapath.
// One opcode per handshake, sequenced through DECODE/EXEC/MEM/WB/RET with registered enables.
module multicycle_ctrl #(
  parameter int OPCODE_WIDTH = 3,
  parameter int MAC_CYCLES   = 4,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  output logic                    RegWEn,
  output logic                    MemWEn,
  output logic                    MemREn,
  output logic                    AluEn,
  output logic                    PCWEn,
  output logic                    illegal,
  output logic                    mem_err,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    retired
);

  localparam int MACW = $clog2(MAC_CYCLES + 1);
  localparam int MEMW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_MAC   = OPCODE_WIDTH'(4);

  localparam logic [MACW-1:0] MAC_LAST = MACW'(MAC_CYCLES - 1);
  localparam logic [MEMW-1:0] MEM_LAST = MEMW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    RET    = 3'd5
  } state_t;

  state_t                  state;
  logic [OPCODE_WIDTH-1:0] opQ;
  logic [MACW-1:0]         macCnt;
  logic [MEMW-1:0]         memCnt;

  function automatic logic isLegal(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_MOV) || (op == OP_MAC);
  endfunction

  // Abort flag must land in the last MEM cycle itself, so it looks at mem_ready directly.
  assign mem_err = (state == MEM) && (memCnt == MEM_LAST) && !mem_ready;

  // Each transition loads the enables of the state being entered, so outputs track state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      opQ         <= '0;
      macCnt      <= '0;
      memCnt      <= '0;
      retired     <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      RegWEn      <= 1'b0;
      MemWEn      <= 1'b0;
      MemREn      <= 1'b0;
      AluEn       <= 1'b0;
      PCWEn       <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      RegWEn  <= 1'b0;
      MemWEn  <= 1'b0;
      MemREn  <= 1'b0;
      AluEn   <= 1'b0;
      PCWEn   <= 1'b0;
      illegal <= 1'b0;
      case (state)
        FETCH: begin
          if (instr_valid) begin
            opQ         <= opcode;
            state       <= DECODE;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            illegal     <= !isLegal(opcode);
          end
        end
        DECODE: begin
          case (opQ)
            OP_LOAD: begin
              state  <= MEM;
              memCnt <= '0;
              MemREn <= 1'b1;
            end
            OP_STORE: begin
              state  <= MEM;
              memCnt <= '0;
              MemWEn <= 1'b1;
            end
            OP_MOV: begin
              state  <= WB;
              RegWEn <= 1'b1;
            end
            OP_MAC: begin
              state  <= EXEC;
              macCnt <= MAC_LAST;
              AluEn  <= 1'b1;
            end
            default: begin
              state       <= FETCH;
              instr_ready <= 1'b1;
              busy        <= 1'b0;
            end
          endcase
        end
        EXEC: begin
          if (macCnt == '0) begin
            state  <= WB;
            RegWEn <= 1'b1;
          end else begin
            macCnt <= macCnt - MACW'(1);
            AluEn  <= 1'b1;
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (opQ == OP_LOAD) begin
              state  <= WB;
              RegWEn <= 1'b1;
            end else begin
              state <= RET;
              PCWEn <= 1'b1;
            end
          end else if (memCnt == MEM_LAST) begin
            state       <= FETCH;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            memCnt <= memCnt + MEMW'(1);
            MemREn <= (opQ == OP_LOAD);
            MemWEn <= (opQ == OP_STORE);
          end
        end
        WB: begin
          state <= RET;
          PCWEn <= 1'b1;
        end
        RET: begin
          retired     <= retired + CNT_WIDTH'(1);
          state       <= FETCH;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
        default: begin
          state       <= FETCH;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus hand sequences
// for memory timeout, ready/timeout collision, reset during MAC and counter wrap.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n, instr_valid, mem_ready;
  logic [2:0] opcode;
  logic instr_ready, RegWEn, MemWEn, MemREn, AluEn, PCWEn, illegal, mem_err, busy;
  logic [15:0] retired;
  logic instr_ready2, RegWEn2, MemWEn2, MemREn2, AluEn2, PCWEn2, illegal2, mem_err2, busy2;
  logic [1:0] retired2;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .mem_ready(mem_ready), .RegWEn(RegWEn), .MemWEn(MemWEn),
    .MemREn(MemREn), .AluEn(AluEn), .PCWEn(PCWEn), .illegal(illegal),
    .mem_err(mem_err), .busy(busy), .retired(retired)
  );

  multicycle_ctrl #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready2),
    .opcode(opcode), .mem_ready(mem_ready), .RegWEn(RegWEn2), .MemWEn(MemWEn2),
    .MemREn(MemREn2), .AluEn(AluEn2), .PCWEn(PCWEn2), .illegal(illegal2),
    .mem_err(mem_err2), .busy(busy2), .retired(retired2)
  );

  // Output bundle: {ready, busy, RegWEn, MemWEn, MemREn, AluEn, PCWEn, illegal, mem_err}
  localparam logic [8:0] E_IDLE = 9'b100000000;
  localparam logic [8:0] E_BUSY = 9'b010000000;
  localparam logic [8:0] E_WB   = 9'b011000000;
  localparam logic [8:0] E_MEMW = 9'b010100000;
  localparam logic [8:0] E_MEMR = 9'b010010000;
  localparam logic [8:0] E_ALU  = 9'b010001000;
  localparam logic [8:0] E_RET  = 9'b010000100;
  localparam logic [8:0] E_ILL  = 9'b010000010;

  typedef struct {
    logic        rstN;
    logic        vld;
    logic [2:0]  op;
    logic        memRdy;
    logic [8:0]  exp;
    logic [15:0] expRet;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic r, input logic v, input logic [2:0] o,
                              input logic m, input logic [8:0] e, input logic [15:0] rt);
    vec_t x;
    x.rstN = r; x.vld = v; x.op = o; x.memRdy = m; x.exp = e; x.expRet = rt;
    return x;
  endfunction

  function automatic logic [8:0] obs();
    return {instr_ready, busy, RegWEn, MemWEn, MemREn, AluEn, PCWEn, illegal, mem_err};
  endfunction

  task automatic step(input logic r, input logic v, input logic [2:0] o, input logic m);
    rst_n = r; instr_valid = v; opcode = o; mem_ready = m;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int errAt, memCycles;
  logic pcSeen;
  logic [1:0] wrapExp[5];

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; opcode = 3'd0; mem_ready = 1'b0;

    tbl[0]  = mk(0, 0, 3'd0, 0, E_IDLE, 0);
    tbl[1]  = mk(0, 1, 3'd2, 0, E_IDLE, 0);   // valid during reset ignored
    tbl[2]  = mk(1, 1, 3'd2, 0, E_BUSY, 0);   // MOV handshake
    tbl[3]  = mk(1, 0, 3'd2, 0, E_WB,   0);
    tbl[4]  = mk(1, 1, 3'd0, 0, E_RET,  0);
    tbl[5]  = mk(1, 1, 3'd0, 0, E_IDLE, 1);   // ready 3 cycles after handshake
    tbl[6]  = mk(1, 1, 3'd0, 0, E_BUSY, 1);   // LOAD handshake
    tbl[7]  = mk(1, 0, 3'd0, 1, E_MEMR, 1);   // mem_ready in DECODE ignored
    tbl[8]  = mk(1, 0, 3'd0, 1, E_WB,   1);
    tbl[9]  = mk(1, 0, 3'd0, 0, E_RET,  1);
    tbl[10] = mk(1, 0, 3'd0, 0, E_IDLE, 2);
    tbl[11] = mk(1, 1, 3'd4, 0, E_BUSY, 2);   // MAC handshake
    tbl[12] = mk(1, 0, 3'd2, 0, E_ALU,  2);   // opcode changes have no effect
    tbl[13] = mk(1, 0, 3'd2, 0, E_ALU,  2);
    tbl[14] = mk(1, 0, 3'd2, 0, E_ALU,  2);
    tbl[15] = mk(1, 0, 3'd2, 0, E_ALU,  2);
    tbl[16] = mk(1, 0, 3'd0, 0, E_WB,   2);
    tbl[17] = mk(1, 0, 3'd0, 0, E_RET,  2);
    tbl[18] = mk(1, 0, 3'd0, 0, E_IDLE, 3);
    tbl[19] = mk(1, 1, 3'd7, 0, E_ILL,  3);   // illegal opcode
    tbl[20] = mk(1, 0, 3'd7, 0, E_IDLE, 3);
    tbl[21] = mk(1, 1, 3'd1, 0, E_BUSY, 3);   // STORE handshake
    tbl[22] = mk(1, 0, 3'd1, 0, E_MEMW, 3);
    tbl[23] = mk(1, 0, 3'd1, 0, E_MEMW, 3);
    tbl[24] = mk(1, 0, 3'd1, 0, E_MEMW, 3);
    tbl[25] = mk(1, 0, 3'd1, 0, E_MEMW, 3);
    tbl[26] = mk(1, 0, 3'd1, 1, E_RET,  3);   // ready at wait 3, no WB
    tbl[27] = mk(1, 0, 3'd1, 0, E_IDLE, 4);

    foreach (tbl[i]) begin
      step(tbl[i].rstN, tbl[i].vld, tbl[i].op, tbl[i].memRdy);
      chk($sformatf("vec%0d_out", i), 32'(obs()), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_ret", i), 32'(retired), 32'(tbl[i].expRet));
    end

    // STORE with no mem_ready: mem_err in the 15th MEM cycle, then FETCH, nothing retired
    step(1, 1, 3'd1, 0);
    memCycles = 0; errAt = 0; pcSeen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 3'd1, 0);
      if (PCWEn) pcSeen = 1'b1;
      if (MemWEn) memCycles++;
      if (mem_err) begin errAt = memCycles; break; end
    end
    chk("timeout_cycle", 32'(errAt), 32'd15);
    step(1, 0, 3'd1, 0);
    if (PCWEn) pcSeen = 1'b1;
    chk("timeout_fetch", 32'({instr_ready, busy, mem_err}), 32'b100);
    chk("timeout_no_pc", 32'(pcSeen), 32'd0);
    chk("timeout_ret", 32'(retired), 32'd4);

    // mem_ready on the final MEM cycle beats the timeout
    step(1, 1, 3'd1, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 3'd1, 0);
    chk("collide_err_pending", 32'({MemWEn, mem_err}), 32'b11);
    mem_ready = 1'b1;
    #1;
    chk("collide_err_masked", 32'(mem_err), 32'd0);
    step(1, 0, 3'd1, 1);
    chk("collide_ret", 32'(obs()), 32'(E_RET));
    step(1, 0, 3'd1, 0);
    chk("collide_count", 32'(retired), 32'd5);

    // reset during MAC EXEC aborts with no PC advance
    step(1, 1, 3'd4, 0);
    step(1, 0, 3'd4, 0);
    step(1, 0, 3'd4, 0);
    chk("mac_in_exec", 32'(AluEn), 32'd1);
    step(0, 0, 3'd0, 0);
    chk("mac_rst_out", 32'(obs()), 32'(E_IDLE));
    chk("mac_rst_ret", 32'(retired), 32'd0);
    step(1, 0, 3'd0, 0);
    chk("mac_rst_after", 32'(obs()), 32'(E_IDLE));

    // 2-bit counter wraps: 1,2,3,0,1
    wrapExp[0] = 2'd1; wrapExp[1] = 2'd2; wrapExp[2] = 2'd3; wrapExp[3] = 2'd0; wrapExp[4] = 2'd1;
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 3'd2, 0);
      step(1, 0, 3'd2, 0);
      step(1, 0, 3'd2, 0);
      step(1, 0, 3'd2, 0);
      chk($sformatf("wrap%0d", k), 32'(retired2), 32'(wrapExp[k]));
    end
    chk("wrap_wide", 32'(retired), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
